// File: rtl/beagleg_spi_responder.sv
// BeagleG host SPI responder: decodes host commands, answers free-slot/status queries and
// assembles motion segments for the FIFO. Optional macro BEAGLEG_SPI_ECHO_EN echoes WRITE bytes on MISO.
module beagleg_spi_responder #(
  parameter int FIFO_DEPTH   = 8,
  parameter int SEGMENT_BITS = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             spi_sck,
  input  logic                             spi_cs_n,
  input  logic                             spi_mosi,
  output logic                             spi_miso,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_free,
  input  logic [31:0]                      status_word,
  output logic [SEGMENT_BITS-1:0]          seg_data,
  output logic                             seg_valid,
  input  logic                             seg_ready,
  output logic                             overflow
);
  localparam int NBYTES = SEGMENT_BITS / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE      = BCW'(NBYTES - 1);
  localparam logic [7:0]     CMD_NO_OP      = 8'd0;
  localparam logic [7:0]     CMD_STATUS     = 8'd1;
  localparam logic [7:0]     CMD_WRITE_FIFO = 8'd2;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RESP, S_WRITE, S_DISCARD} state_t;

  state_t                  state_q;
  logic [1:0]              sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                    sck_prev_q, cs_prev_q;
  logic [2:0]              bit_cnt_q;
  logic [BCW-1:0]          byte_cnt_q;
  logic [6:0]              rx_q;
  logic [31:0]             resp_q;
  logic [5:0]              resp_cnt_q;
  logic [SEGMENT_BITS-1:0] shift_q;
`ifdef BEAGLEG_SPI_ECHO_EN
  logic [7:0]              echo_q;
`endif

  logic                    sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
  logic [7:0]              rx_byte_s;
  logic [SEGMENT_BITS-1:0] seg_next_s;
  logic                    unused_status_s;

  assign unused_status_s = status_word[31];

  // Edge detection on synchronized pins and next-segment image with the current byte inserted
  always_comb begin
    sck_rise_s =  sck_sync_q[1] & ~sck_prev_q;
    sck_fall_s = ~sck_sync_q[1] &  sck_prev_q;
    cs_rise_s  =  cs_sync_q[1]  & ~cs_prev_q;
    cs_fall_s  = ~cs_sync_q[1]  &  cs_prev_q;
    rx_byte_s  = {rx_q, mosi_sync_q[1]};
    seg_next_s = shift_q;
    seg_next_s[8*byte_cnt_q +: 8] = rx_byte_s;
  end

  // Synchronizers, protocol FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      rx_q        <= 7'd0;
      resp_q      <= 32'd0;
      resp_cnt_q  <= 6'd0;
      shift_q     <= '0;
      spi_miso    <= 1'b0;
      seg_data    <= '0;
      seg_valid   <= 1'b0;
      overflow    <= 1'b0;
`ifdef BEAGLEG_SPI_ECHO_EN
      echo_q      <= 8'd0;
`endif
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sck_prev_q  <= sck_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];

      // a load later in this block overrides the handshake clear
      if (seg_valid && seg_ready) seg_valid <= 1'b0;

      if (cs_rise_s) begin
        state_q    <= S_IDLE;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= '0;
        spi_miso   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_fall_s) begin
              state_q    <= S_CMD;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= '0;
              spi_miso   <= 1'b0;
            end
          end
          S_CMD: begin
            if (sck_rise_s) begin
              rx_q      <= rx_byte_s[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                case (rx_byte_s)
                  CMD_NO_OP: begin
                    resp_q     <= {8'(fifo_free), 24'd0};
                    resp_cnt_q <= 6'd8;
                    state_q    <= S_RESP;
                  end
                  CMD_STATUS: begin
                    resp_q     <= {overflow, status_word[30:0]};
                    resp_cnt_q <= 6'd32;
                    overflow   <= 1'b0;
                    state_q    <= S_RESP;
                  end
                  CMD_WRITE_FIFO: begin
                    byte_cnt_q <= '0;
                    state_q    <= S_WRITE;
`ifdef BEAGLEG_SPI_ECHO_EN
                    echo_q     <= rx_byte_s;
`endif
                  end
                  default: state_q <= S_DISCARD;
                endcase
              end
            end
          end
          S_RESP: begin
            if (sck_fall_s) begin
              if (resp_cnt_q != 6'd0) begin
                spi_miso   <= resp_q[31];
                resp_q     <= {resp_q[30:0], 1'b0};
                resp_cnt_q <= resp_cnt_q - 6'd1;
              end else begin
                spi_miso <= 1'b0;
              end
            end
          end
          S_WRITE: begin
            if (sck_rise_s) begin
              rx_q      <= rx_byte_s[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                shift_q <= seg_next_s;
`ifdef BEAGLEG_SPI_ECHO_EN
                echo_q  <= rx_byte_s;
`endif
                if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_q <= '0;
                  if (!seg_valid || seg_ready) begin
                    seg_data  <= seg_next_s;
                    seg_valid <= 1'b1;
                  end else begin
                    overflow <= 1'b1;
                  end
                end else begin
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                end
              end
            end
            if (sck_fall_s) begin
`ifdef BEAGLEG_SPI_ECHO_EN
              spi_miso <= echo_q[7];
              echo_q   <= {echo_q[6:0], 1'b0};
`else
              spi_miso <= 1'b0;
`endif
            end
          end
          S_DISCARD: spi_miso <= 1'b0;
          default:   state_q  <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_beagleg_spi_responder.sv
// Self-checking bench for beagleg_spi_responder: bit-banged SPI host plus MISO/segment scoreboards.
module tb_beagleg_spi_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic         spi_miso;
  logic [3:0]   fifo_free = 4'd0;
  logic [31:0]  status_word = 32'd0;
  logic [127:0] seg_data;
  logic         seg_valid;
  logic         seg_ready = 1'b1;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   miso_exp_q[$];
  logic [127:0] seg_exp_q[$];
  logic [127:0] seg_got_q[$];

  beagleg_spi_responder #(.FIFO_DEPTH(8), .SEGMENT_BITS(128)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .fifo_free(fifo_free), .status_word(status_word),
    .seg_data(seg_data), .seg_valid(seg_valid), .seg_ready(seg_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Record every segment the FIFO side accepts
  always @(negedge clk) begin
    if (rst_n && seg_valid && seg_ready) seg_got_q.push_back(seg_data);
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (8) @(negedge clk);
      spi_sck = 1'b1;
      rx[i] = spi_miso;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (16) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_seg(input logic [127:0] s, output logic [7:0] rx_or);
    logic [7:0] rx;
    rx_or = 8'h00;
    for (int k = 0; k < 16; k++) begin
      spi_byte(s[8*k +: 8], rx);
      rx_or = rx_or | rx;
    end
  endtask

  task automatic check_segs(input string name);
    if (seg_got_q.size() !== seg_exp_q.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s count: got %0d segments, expected %0d", name, seg_got_q.size(), seg_exp_q.size());
    end
    while (seg_exp_q.size() > 0 && seg_got_q.size() > 0) begin
      logic [127:0] e, g;
      e = seg_exp_q.pop_front();
      g = seg_got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s data: got %h expected %h", name, g, e);
      end
    end
    seg_exp_q.delete();
    seg_got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({spi_miso, seg_valid, overflow} !== 3'b000 || seg_data !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_in: got miso=%b valid=%b ovf=%b data=%h expected all 0", spi_miso, seg_valid, overflow, seg_data);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({spi_miso, seg_valid, overflow} !== 3'b000 || seg_data !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_after: got miso=%b valid=%b ovf=%b data=%h expected all 0", spi_miso, seg_valid, overflow, seg_data);
    end
  endtask

  task automatic test_free_query(input logic [3:0] ff);
    logic [7:0] rx, e;
    fifo_free = ff;
    cs_begin();
    spi_byte(8'h00, rx);
    n_cmp++;
    if (rx !== 8'h00) begin
      n_bad++;
      $display("FAIL free_cmd_miso: got %h expected 00", rx);
    end
    miso_exp_q.push_back({4'h0, ff});
    spi_byte(8'hFF, rx);
    e = miso_exp_q.pop_front();
    n_cmp++;
    if (rx !== e) begin
      n_bad++;
      $display("FAIL free_resp: got %h expected %h", rx, e);
    end
    cs_end();
  endtask

  task automatic test_status(input logic exp_ovf);
    logic [7:0] rx, e;
    logic [31:0] w;
    status_word = 32'h1234_5678;
    w = {exp_ovf, status_word[30:0]};
    for (int b = 3; b >= 0; b--) miso_exp_q.push_back(w[8*b +: 8]);
    cs_begin();
    spi_byte(8'h01, rx);
    for (int b = 0; b < 4; b++) begin
      spi_byte(8'h00, rx);
      e = miso_exp_q.pop_front();
      n_cmp++;
      if (rx !== e) begin
        n_bad++;
        $display("FAIL status_byte%0d: got %h expected %h", b, rx, e);
      end
    end
    cs_end();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL status_ovf: got %b expected 0", overflow);
    end
  endtask

  task automatic test_write();
    logic [7:0] rx, rx_or;
    logic [127:0] s;
    s = 128'h00000004_00000003_00000002_00000001;
    seg_ready = 1'b1;
    seg_exp_q.push_back(s);
    cs_begin();
    spi_byte(8'h02, rx);
    send_seg(s, rx_or);
    cs_end();
    n_cmp++;
    if (rx_or !== 8'h00) begin
      n_bad++;
      $display("FAIL write_miso: got %h expected 00", rx_or);
    end
    check_segs("write");
  endtask

  task automatic test_overflow();
    logic [7:0] rx, rx_or;
    logic [127:0] a, b;
    a = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    b = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    seg_ready = 1'b0;
    cs_begin();
    spi_byte(8'h02, rx);
    send_seg(a, rx_or);
    send_seg(b, rx_or);
    cs_end();
    n_cmp++;
    if (seg_valid !== 1'b1 || seg_data !== a || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_hold: got valid=%b ovf=%b data=%h expected 1 1 %h", seg_valid, overflow, seg_data, a);
    end
    test_status(1'b1);
    seg_exp_q.push_back(a);
    seg_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_segs("ovf_drain");
    n_cmp++;
    if (seg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_valid_drop: got %b expected 0", seg_valid);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx, rx_or;
    logic [127:0] c;
    c = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    seg_ready = 1'b1;
    cs_begin();
    spi_byte(8'h02, rx);
    for (int k = 0; k < 7; k++) spi_byte(8'hE0 + 8'(k), rx);
    cs_end();
    seg_exp_q.push_back(c);
    cs_begin();
    spi_byte(8'h02, rx);
    send_seg(c, rx_or);
    cs_end();
    check_segs("abort");
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx, rx_or;
    rx_or = 8'h00;
    cs_begin();
    spi_byte(8'h07, rx);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'h02, rx);
      rx_or = rx_or | rx;
    end
    cs_end();
    n_cmp++;
    if (rx_or !== 8'h00 || seg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_cmd: got miso_or=%h valid=%b expected 00 0", rx_or, seg_valid);
    end
    check_segs("bad_cmd");
    test_free_query(4'd3);
  endtask

  initial begin
    test_reset();
    test_free_query(4'd5);
    test_status(1'b0);
    test_write();
    test_overflow();
    test_abort();
    test_bad_cmd();
    test_free_query(4'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/beagleg_spi_responder.md
# beagleg_spi_responder

FPGA-side responder for the BeagleG host protocol. It receives SPI transactions from the host and decodes the command byte (`CMD_NO_OP`=0, `CMD_STATUS`=1, `CMD_WRITE_FIFO`=2). It answers free-slot and status queries, and assembles 128-bit `motion_segment_t` words that it hands to the segment FIFO over a valid/ready port. It sits between the SPI pins and the motion FIFO feeding the step generator.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 8: segment FIFO depth; width of `fifo_free` is `$clog2(FIFO_DEPTH+1)`.
- `SEGMENT_BITS`, default 128: `motion_segment_t` width (4 x 32).

**Ports**
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous active-low.
- `spi_sck` in 1: SPI clock from host, asynchronous.
- `spi_cs_n` in 1: chip select, active-low, asynchronous.
- `spi_mosi` in 1: host-to-FPGA data.
- `spi_miso` out 1: FPGA-to-host data.
- `fifo_free` in `$clog2(FIFO_DEPTH+1)`: current free FIFO slots.
- `status_word` in 32: status from motion core.
- `seg_data` out `SEGMENT_BITS`: assembled segment.
- `seg_valid` out 1: `seg_data` valid.
- `seg_ready` in 1: FIFO accepts `seg_data`.
- `overflow` out 1: sticky; segment dropped because output register was occupied.

## Operation

- SPI mode 0, MSB-first per byte.
- `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through 2-flop synchronizers. Edges are detected on the synchronized `spi_sck`:
  - MOSI is sampled on the rising edge.
  - MISO is updated on the falling edge.
  - Requirement: SCK period ≥ 8 `clk`.
- `spi_cs_n` rising (synchronized) from any state: go to IDLE, clear the bit/byte counters and discard any partial segment. An already-valid `seg_data` is kept.
- States:
  - **IDLE**: waiting for `spi_cs_n` to fall; then → CMD.
  - **CMD**: shift 8 bits, then decode:
    - 0 → RESP with `fifo_free` zero-extended to 8 bits latched as a 1-byte response.
    - 1 → RESP with `{overflow, status_word[30:0]}` latched as a 4-byte response; `overflow` clears in the same cycle.
    - 2 → WRITE.
    - other → DISCARD.
  - **RESP**: shift the latched response MSB-first, starting with the first bit of the byte after the command. Once exhausted, MISO=0 until CS rises.
  - **WRITE**: byte k (0..15) of each 16-byte group goes to `shift[8k+7:8k]`, i.e. C little-endian order with `target_steps` first. On the 16th byte:
    - if `seg_valid`=0 or `seg_ready`=1 in that cycle: load `seg_data` and assert `seg_valid`;
    - else drop the segment and set `overflow`.
    - Then continue with the next group.
  - **DISCARD**: ignore MOSI, MISO=0, until CS rises.
- `seg_valid` deasserts the cycle after `seg_valid && seg_ready`, unless a new segment loads in that same cycle.
- MISO is 0 during the command byte and in WRITE (see Configuration).

## Timing

- Reset values: `spi_miso`=0, `seg_valid`=0, `seg_data`=0, `overflow`=0, state IDLE.
- Pin-to-internal latency: 2 `clk` synchronizer + 1 `clk` edge detect.
- `seg_valid` rises 1 `clk` after the detected rising SCK edge of the 128th data bit.
- The command latches `fifo_free` / `status_word` 1 `clk` after the 8th command bit's rising edge.
- MISO changes 1 `clk` after the detected falling SCK edge. The first response bit is driven at the falling edge ending the command byte.
- Reset mid-transaction: immediate return to IDLE and all outputs 0. The rest of the host transfer is ignored until the next CS fall.
- CS fall and first SCK rise must be ≥ 4 `clk` apart.

## Configuration

- `BEAGLEG_SPI_ECHO_EN` defined: in WRITE, MISO returns each received byte during the following byte (the first data byte echoes the command byte, 0x02). The host uses this for link verification.
- Not defined: MISO=0 throughout WRITE and the echo register is not synthesized.

## Test plan

- Reset, then CS low, send 0x00 plus one dummy byte with `fifo_free`=5 → MISO byte 0x05; all outputs 0 before the transfer.
- Send 0x01 plus 4 dummy bytes with `status_word`=0x1234_5678 and `overflow`=0 → MISO bytes 12 34 56 78; `overflow` stays 0.
- Send 0x02 then bytes 01 00 00 00, 02 00 00 00, 03 00 00 00, 04 00 00 00 with `seg_ready`=1 → one `seg_valid` pulse with `seg_data`=0x00000004_00000003_00000002_00000001.
- `seg_ready`=0, two consecutive segments → first held valid, second dropped, `overflow`=1. A following 0x01 read returns a first byte with bit 7 set and clears `overflow`.
- 0x02 plus 7 bytes, then CS high, then a new 0x02 plus a full 16 bytes → exactly one segment, equal to the second transfer's data.
- Command 0x07 plus 4 bytes → MISO all 0, no `seg_valid`; a following 0x00 query responds correctly.
